// File: rtl/bp_update_ctrl_pkg.sv
// rtl/bp_update_ctrl_pkg.sv - shared widths, jump flags, zero word and FSM encoding for bp_update_ctrl
package bp_update_ctrl_pkg;

    localparam int unsigned INST_ADDR_W  = 32;
    localparam logic        JUMP_ENABLE  = 1'b1;
    localparam logic        JUMP_DISABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } bp_state_e;

endpackage

// File: rtl/bp_fifo.sv
// rtl/bp_fifo.sv - synchronous FIFO with push, pop and single-cycle clear (clear beats push)
module bp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next pointers, occupancy and storage; clear empties everything and drops a same-cycle push
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Pointer/occupancy registers; storage needs no reset since occupancy guards it
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// rtl/bp_update_ctrl.sv - in-order branch resolution, predictor training and mispredict flush; optional stats under BPU_STATS_EN
module bp_update_ctrl
    import bp_update_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = INST_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid_i,
    output logic                     pred_ready_o,
    input  logic [AW-1:0]            pred_pc_i,
    input  logic                     pred_taken_i,
    input  logic [AW-1:0]            pred_target_i,
    input  logic                     res_valid_i,
    input  logic                     res_taken_i,
    input  logic [AW-1:0]            res_target_i,
    output logic                     upd_valid_o,
    output logic [AW-1:0]            upd_pc_o,
    output logic                     upd_taken_o,
    output logic                     flush_o,
    output logic [AW-1:0]            redirect_addr_o,
    output logic [$clog2(DEPTH):0]   inflight_o,
    output logic                     err_o,
    output logic [31:0]              stat_resolved_o,
    output logic [31:0]              stat_mispred_o
);

    localparam int unsigned EW = 2 * AW + 1;

    bp_state_e     state_q, state_d;
    logic          upd_valid_q, upd_valid_d;
    logic [AW-1:0] upd_pc_q, upd_pc_d;
    logic          upd_taken_q, upd_taken_d;
    logic          flush_q, flush_d;
    logic [AW-1:0] redirect_q, redirect_d;
    logic          err_q, err_d;

    logic [EW-1:0] head;
    logic [AW-1:0] head_pc;
    logic          head_taken;
    logic [AW-1:0] head_target;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          mispred;
    logic          clear;

    // Entries are packed as {pc, taken, target}
    assign head_pc     = head[EW-1 -: AW];
    assign head_taken  = head[AW];
    assign head_target = head[AW-1:0];

    assign push    = pred_valid_i && pred_ready_o;
    assign pop     = res_valid_i && !fifo_empty;
    assign mispred = (res_taken_i != head_taken) || (res_taken_i && (res_target_i != head_target));
    assign clear   = pop && mispred;

    bp_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({pred_pc_i, pred_taken_i, pred_target_i}),
        .pop_i   (pop),
        .clear_i (clear),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (inflight_o)
    );

    // FSM: a mispredict parks fetch for one RECOVER cycle while the wrong path drains
    always_comb begin
        state_d      = state_q;
        pred_ready_o = 1'b0;
        case (state_q)
            ST_RUN: begin
                pred_ready_o = !fifo_full;
                if (clear) state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Next values of the one-cycle training/flush pulses and the sticky empty-queue error
    always_comb begin
        upd_valid_d = pop;
        upd_pc_d    = pop ? head_pc : '0;
        upd_taken_d = pop && res_taken_i;
        flush_d     = clear ? JUMP_ENABLE : JUMP_DISABLE;
        redirect_d  = '0;
        if (clear) begin
            redirect_d = res_taken_i ? res_target_i : head_pc + AW'(4);
        end
        err_d = err_q || (res_valid_i && fifo_empty);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            upd_valid_q <= 1'b0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            upd_valid_q <= upd_valid_d;
            upd_pc_q    <= upd_pc_d;
            upd_taken_q <= upd_taken_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            err_q       <= err_d;
        end
    end

    assign upd_valid_o     = upd_valid_q;
    assign upd_pc_o        = upd_pc_q;
    assign upd_taken_o     = upd_taken_q;
    assign flush_o         = flush_q;
    assign redirect_addr_o = redirect_q;
    assign err_o           = err_q;

`ifdef BPU_STATS_EN
    logic [31:0] stat_res_q, stat_res_d;
    logic [31:0] stat_mis_q, stat_mis_d;

    // Free-running wrap-around counters of resolutions and mispredicts
    always_comb begin
        stat_res_d = stat_res_q + {31'd0, pop};
        stat_mis_d = stat_mis_q + {31'd0, clear};
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_res_q <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_res_q <= stat_res_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_resolved_o = stat_res_q;
    assign stat_mispred_o  = stat_mis_q;
`else
    assign stat_resolved_o = ZERO_WORD;
    assign stat_mispred_o  = ZERO_WORD;
`endif

endmodule
